control_unit: RTL and testbench

Multicycle control FSM for the RV64I CPU datapath. It decodes the instruction register fields and drives every load, write and select strobe in the datapath: PC, instruction register, register bank, A/B, ALUOut and memory-data registers, the two ALU operand muxes, the ALU operation and data-memory write. It sits beside the datapath inside `CPU` and is the only source of its control signals.

---
 rtl/cpu_ctrl_pkg.sv | 68 ++++++
 rtl/ctrl_decode.sv | 27 ++
 rtl/control_unit.sv | 167 ++++++++++++++++
 tb/tb_control_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV64I control unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        RESET_ST = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        EXEC_I   = 4'd4,
        ALU_WB   = 4'd5,
        ADDR     = 4'd6,
        MEM_RD   = 4'd7,
        LD_WB    = 4'd8,
        MEM_WR   = 4'd9,
        BRANCH   = 4'd10,
        LUI      = 4'd11,
        HALT     = 4'd12,
        ILLEGAL  = 4'd13
    } state_t;

    typedef enum logic [2:0] {
        CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_LUI, CLS_SYSTEM, CLS_BAD
    } iclass_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;

    localparam logic [2:0] A_PC      = 3'd0;
    localparam logic [2:0] A_REG     = 3'd1;
    localparam logic [2:0] A_ZERO    = 3'd2;
    localparam logic [2:0] A_PC_PREV = 3'd3;

    localparam logic [2:0] B_REG     = 3'd0;
    localparam logic [2:0] B_FOUR    = 3'd1;
    localparam logic [2:0] B_IMM     = 3'd2;
    localparam logic [2:0] B_IMM_SH1 = 3'd3;

    typedef struct packed {
        logic       pc_write;
        logic       ir_load;
        logic       a_load;
        logic       b_load;
        logic       aluout_load;
        logic       mdr_load;
        logic       regfile_write;
        logic       wb_sel;
        logic       mem_wr;
        logic [2:0] alu_a_sel;
        logic [2:0] alu_b_sel;
        logic [2:0] alu_op;
        logic       halted;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Classifies the IR opcode/funct fields into the instruction classes the FSM dispatches on.
// Latency: combinational.
// Backpressure: none.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output iclass_t    iclass
);

    always_comb begin
        iclass = CLS_BAD;
        case (opcode)
            OP_R:      if (funct3 == 3'b000 && (funct7 == F7_ADD || funct7 == F7_SUB)) iclass = CLS_R;
            OP_IMM:    if (funct3 == 3'b000) iclass = CLS_I;
            OP_LOAD:   if (funct3 == 3'b011) iclass = CLS_LOAD;
            OP_STORE:  if (funct3 == 3'b011) iclass = CLS_STORE;
            OP_BRANCH: if (funct3 == 3'b000 || funct3 == 3'b001) iclass = CLS_BRANCH;
            OP_LUI:    iclass = CLS_LUI;
            OP_SYSTEM: iclass = CLS_SYSTEM;
            default:   iclass = CLS_BAD;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle control FSM driving every datapath strobe and select of the RV64I CPU.
// Latency: R/I/LUI 4+W, load 5+2W, store 4+W, branch 3+W cycles (W = MEM_WAIT).
// Backpressure: none; memory waits are a fixed MEM_WAIT count, HALT/ILLEGAL hold until reset.
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic [4:0] rd,
    input  logic       alu_zero,
    output logic       pc_write,
    output logic       pc_src,
    output logic       ir_load,
    output logic       a_load,
    output logic       b_load,
    output logic       aluout_load,
    output logic       mdr_load,
    output logic       regfile_write,
    output logic       wb_sel,
    output logic       mem_wr,
    output logic [2:0] alu_a_sel,
    output logic [2:0] alu_b_sel,
    output logic [2:0] alu_op,
    output logic       halted,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    state_t  state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    ctrl_t   ctl_q;
    iclass_t iclass;
    logic    branch_taken;

    ctrl_decode u_decode (
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .iclass (iclass)
    );

    // Strobes for the state being entered, so they can be registered one edge ahead.
    function automatic ctrl_t moore_ctrl(input state_t s, input logic [2:0] c,
                                         input logic [6:0] f7, input logic [4:0] rd_f);
        ctrl_t o;
        o = '0;
        case (s)
            FETCH: if (c == WAIT_LAST) begin
                o.ir_load   = 1'b1;
                o.pc_write  = 1'b1;
                o.alu_a_sel = A_PC;
                o.alu_b_sel = B_FOUR;
                o.alu_op    = ALU_ADD;
            end
            DECODE: begin
                o.a_load      = 1'b1;
                o.b_load      = 1'b1;
                o.aluout_load = 1'b1;
                o.alu_a_sel   = A_PC_PREV;
                o.alu_b_sel   = B_IMM_SH1;
                o.alu_op      = ALU_ADD;
            end
            EXEC_R: begin
                o.aluout_load = 1'b1;
                o.alu_a_sel   = A_REG;
                o.alu_b_sel   = B_REG;
                o.alu_op      = (f7 == F7_SUB) ? ALU_SUB : ALU_ADD;
            end
            EXEC_I, ADDR: begin
                o.aluout_load = 1'b1;
                o.alu_a_sel   = A_REG;
                o.alu_b_sel   = B_IMM;
                o.alu_op      = ALU_ADD;
            end
            LUI: begin
                o.aluout_load = 1'b1;
                o.alu_a_sel   = A_ZERO;
                o.alu_b_sel   = B_IMM;
                o.alu_op      = ALU_ADD;
            end
            ALU_WB:  o.regfile_write = (rd_f != 5'd0);
            MEM_RD:  o.mdr_load = (c == WAIT_LAST);
            LD_WB: begin
                o.regfile_write = (rd_f != 5'd0);
                o.wb_sel        = 1'b1;
            end
            MEM_WR:  o.mem_wr = 1'b1;
            BRANCH: begin
                o.alu_a_sel = A_REG;
                o.alu_b_sel = B_REG;
                o.alu_op    = ALU_SUB;
            end
            HALT:    o.halted  = 1'b1;
            ILLEGAL: o.illegal = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = 3'd0;
        case (state_q)
            // Counter doubles as the one-cycle idle marker after reset release.
            RESET_ST: if (cnt_q == 3'd0) cnt_d = 3'd1; else state_d = FETCH;
            FETCH:    if (cnt_q == WAIT_LAST) state_d = DECODE; else cnt_d = cnt_q + 3'd1;
            DECODE: begin
                case (iclass)
                    CLS_R:                state_d = EXEC_R;
                    CLS_I:                state_d = EXEC_I;
                    CLS_LOAD, CLS_STORE:  state_d = ADDR;
                    CLS_BRANCH:           state_d = BRANCH;
                    CLS_LUI:              state_d = LUI;
                    CLS_SYSTEM:           state_d = HALT;
                    default:              state_d = ILLEGAL;
                endcase
            end
            EXEC_R, EXEC_I, LUI:             state_d = ALU_WB;
            ADDR:    state_d = (iclass == CLS_LOAD) ? MEM_RD : MEM_WR;
            MEM_RD:  if (cnt_q == WAIT_LAST) state_d = LD_WB; else cnt_d = cnt_q + 3'd1;
            ALU_WB, LD_WB, MEM_WR, BRANCH:   state_d = FETCH;
            HALT, ILLEGAL:                   state_d = state_q;
            default:                         state_d = RESET_ST;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RESET_ST;
            cnt_q   <= 3'd0;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctl_q   <= moore_ctrl(state_d, cnt_d, funct7, rd);
        end
    end

    // The branch decision needs this cycle's ALU compare, so it bypasses the output flops.
    assign branch_taken = (state_q == BRANCH) &&
                          ((funct3 == 3'b000 && alu_zero) || (funct3 == 3'b001 && !alu_zero));

    assign pc_write      = ctl_q.pc_write | branch_taken;
    assign pc_src        = branch_taken;
    assign ir_load       = ctl_q.ir_load;
    assign a_load        = ctl_q.a_load;
    assign b_load        = ctl_q.b_load;
    assign aluout_load   = ctl_q.aluout_load;
    assign mdr_load      = ctl_q.mdr_load;
    assign regfile_write = ctl_q.regfile_write;
    assign wb_sel        = ctl_q.wb_sel;
    assign mem_wr        = ctl_q.mem_wr;
    assign alu_a_sel     = ctl_q.alu_a_sel;
    assign alu_b_sel     = ctl_q.alu_b_sel;
    assign alu_op        = ctl_q.alu_op;
    assign halted        = ctl_q.halted;
    assign illegal       = ctl_q.illegal;
    assign state         = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: instruction table with per-instruction tallies, reset corner cases,
// and random instructions checked cycle by cycle against a trace model.
module tb_control_unit;

    localparam int W     = 1;
    localparam int LIMIT = 25;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic [4:0] rd = '0;
    logic       alu_zero = 1'b0;
    logic       pc_write, pc_src, ir_load, a_load, b_load, aluout_load, mdr_load;
    logic       regfile_write, wb_sel, mem_wr, halted, illegal;
    logic [2:0] alu_a_sel, alu_b_sel, alu_op;
    logic [3:0] state;

    control_unit #(.MEM_WAIT(W)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .alu_zero(alu_zero), .pc_write(pc_write), .pc_src(pc_src),
        .ir_load(ir_load), .a_load(a_load), .b_load(b_load), .aluout_load(aluout_load),
        .mdr_load(mdr_load), .regfile_write(regfile_write), .wb_sel(wb_sel),
        .mem_wr(mem_wr), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
        .halted(halted), .illegal(illegal), .state(state)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] st;
        logic pcw, pcs, irl, al, bl, aol, mdl, rfw, wbs, mw;
        logic [2:0] asel, bsel, aop;
        logic hlt, ill;
    } obs_t;

    obs_t obs;
    assign obs = {state, pc_write, pc_src, ir_load, a_load, b_load, aluout_load, mdr_load,
                  regfile_write, wb_sel, mem_wr, alu_a_sel, alu_b_sel, alu_op, halted, illegal};

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] rd;
        bit         z;
        int len, rfw, mw, mdr, pcw, wbs, stat, eop;
        logic [3:0] endst;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    obs_t exp_q[$];
    bit   exp_absorb;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Asserts reset, checks outputs clear at once, releases, and stops in the first FETCH cycle.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        chk({tag, ".rst_outputs"}, 32'(obs), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock); #1;
        chk({tag, ".rst_idle"}, 32'(state), 32'd0);
        @(negedge clock); #1;
        chk({tag, ".rst_fetch"}, 32'(state), 32'd1);
    endtask

    function automatic obs_t blank(input logic [3:0] s);
        obs_t o;
        o = '0;
        o.st = s;
        return o;
    endfunction

    function automatic obs_t fetch_obs(input int i);
        obs_t o;
        o = blank(4'd1);
        if (i == W) begin
            o.irl = 1; o.pcw = 1; o.asel = 3'd0; o.bsel = 3'd1; o.aop = 3'd1;
        end
        return o;
    endfunction

    // Expected per-cycle trace of one instruction, built from the instruction's class.
    task automatic build_model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [4:0] r, input bit z);
        obs_t o;
        bit is_r, is_i, is_ld, is_st, is_br, is_lui, is_sys, taken;
        exp_q.delete();
        exp_absorb = 0;
        for (int i = 0; i <= W; i++) exp_q.push_back(fetch_obs(i));
        o = blank(4'd2);
        o.al = 1; o.bl = 1; o.aol = 1; o.asel = 3'd3; o.bsel = 3'd3; o.aop = 3'd1;
        exp_q.push_back(o);
        is_r   = (op == 7'h33) && (f3 == 3'd0) && (f7 == 7'h00 || f7 == 7'h20);
        is_i   = (op == 7'h13) && (f3 == 3'd0);
        is_ld  = (op == 7'h03) && (f3 == 3'd3);
        is_st  = (op == 7'h23) && (f3 == 3'd3);
        is_br  = (op == 7'h63) && (f3 <= 3'd1);
        is_lui = (op == 7'h37);
        is_sys = (op == 7'h73);
        if (is_r || is_i || is_lui) begin
            o = blank(is_r ? 4'd3 : (is_i ? 4'd4 : 4'd11));
            o.aol  = 1;
            o.aop  = (is_r && f7 == 7'h20) ? 3'd2 : 3'd1;
            o.asel = is_lui ? 3'd2 : 3'd1;
            o.bsel = is_r ? 3'd0 : 3'd2;
            exp_q.push_back(o);
            o = blank(4'd5);
            o.rfw = (r != 0);
            exp_q.push_back(o);
        end else if (is_ld || is_st) begin
            o = blank(4'd6);
            o.aol = 1; o.asel = 3'd1; o.bsel = 3'd2; o.aop = 3'd1;
            exp_q.push_back(o);
            if (is_ld) begin
                for (int i = 0; i <= W; i++) begin
                    o = blank(4'd7);
                    o.mdl = (i == W);
                    exp_q.push_back(o);
                end
                o = blank(4'd8);
                o.rfw = (r != 0); o.wbs = 1;
                exp_q.push_back(o);
            end else begin
                o = blank(4'd9);
                o.mw = 1;
                exp_q.push_back(o);
            end
        end else if (is_br) begin
            taken = (f3 == 3'd0) ? z : !z;
            o = blank(4'd10);
            o.asel = 3'd1; o.bsel = 3'd0; o.aop = 3'd2; o.pcw = taken; o.pcs = taken;
            exp_q.push_back(o);
        end else begin
            exp_absorb = 1;
            for (int i = 0; i < 3; i++) begin
                o = blank(is_sys ? 4'd12 : 4'd13);
                o.hlt = is_sys; o.ill = !is_sys;
                exp_q.push_back(o);
            end
        end
        if (!exp_absorb) exp_q.push_back(fetch_obs(0));
    endtask

    // Runs one instruction from its first FETCH cycle and tallies strobes until FETCH is re-entered.
    task automatic measure(input vec_t v);
        int len, rfw, mw, mdr, pcw, wbs, stat, late, eop;
        logic [3:0] prev;
        logic any;
        len = LIMIT; rfw = 0; mw = 0; mdr = 0; pcw = 0; wbs = 0; stat = 0; late = 0; eop = 0;
        prev = 4'd0;
        opcode = v.op; funct3 = v.f3; funct7 = v.f7; rd = v.rd; alu_zero = v.z;
        #1;
        for (int c = 0; c < LIMIT; c++) begin
            if (c > 0) begin @(negedge clock); #1; end
            if (c > 0 && state == 4'd1 && prev != 4'd1) begin len = c; break; end
            prev = state;
            rfw += int'(regfile_write); mw += int'(mem_wr); mdr += int'(mdr_load);
            pcw += int'(pc_write); wbs += int'(wb_sel);
            if (state inside {4'd3, 4'd4, 4'd6, 4'd10, 4'd11}) eop = int'(alu_op);
            if (state >= 4'd12) begin
                stat++;
                any = pc_write | pc_src | ir_load | a_load | b_load | aluout_load | mdr_load |
                      regfile_write | wb_sel | mem_wr | (|alu_a_sel) | (|alu_b_sel) | (|alu_op);
                if (any) late++;
            end
        end
        chk({v.name, ".len"},   32'(len),  32'(v.len));
        chk({v.name, ".rfw"},   32'(rfw),  32'(v.rfw));
        chk({v.name, ".memwr"}, 32'(mw),   32'(v.mw));
        chk({v.name, ".mdr"},   32'(mdr),  32'(v.mdr));
        chk({v.name, ".pcw"},   32'(pcw),  32'(v.pcw));
        chk({v.name, ".wbsel"}, 32'(wbs),  32'(v.wbs));
        chk({v.name, ".stat"},  32'(stat), 32'(v.stat));
        chk({v.name, ".aluop"}, 32'(eop),  32'(v.eop));
        chk({v.name, ".end"},   32'(state), 32'(v.endst));
        if (v.stat != 0) begin
            chk({v.name, ".absorb_strobes"}, 32'(late), 32'd0);
            do_reset(v.name);
        end
    endtask

    task automatic run_random(input int n);
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic [4:0] r;
        bit z;
        for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 8))
                0: op = 7'h33; 1: op = 7'h13; 2: op = 7'h03; 3: op = 7'h23;
                4: op = 7'h63; 5: op = 7'h37; 6: op = 7'h63;
                7: op = ($urandom_range(0, 3) == 0) ? 7'h73 : 7'h33;
                default: op = 7'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0, 1: f3 = 3'd0; 2: f3 = 3'd1; 3: f3 = 3'd3;
                default: f3 = 3'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0, 1: f7 = 7'h00; 2: f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            r = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            z = 1'($urandom);
            opcode = op; funct3 = f3; funct7 = f7; rd = r; alu_zero = z;
            build_model(op, f3, f7, r, z);
            #1;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (i > 0) begin @(negedge clock); #1; end
                checks++;
                if (obs !== exp_q[i]) begin
                    failures++;
                    $display("FAIL rand%0d op=%h f3=%0d f7=%h rd=%0d z=%0d cyc%0d got=%h exp=%h",
                             k, op, f3, f7, r, z, i, obs, exp_q[i]);
                end
            end
            if (exp_absorb) do_reset("rand");
        end
    endtask

    initial begin
        //            name      op     f3    f7     rd    z  len rfw mw mdr pcw wbs stat eop end
        tbl.push_back('{"add",    7'h33, 3'd0, 7'h00, 5'd3, 0, 5,  1,  0, 0,  1,  0,  0,   1, 4'd1});
        tbl.push_back('{"sub_x0", 7'h33, 3'd0, 7'h20, 5'd0, 0, 5,  0,  0, 0,  1,  0,  0,   2, 4'd1});
        tbl.push_back('{"addi_x0",7'h13, 3'd0, 7'h00, 5'd0, 0, 5,  0,  0, 0,  1,  0,  0,   1, 4'd1});
        tbl.push_back('{"lui",    7'h37, 3'd5, 7'h12, 5'd7, 0, 5,  1,  0, 0,  1,  0,  0,   1, 4'd1});
        tbl.push_back('{"ld",     7'h03, 3'd3, 7'h00, 5'd5, 0, 7,  1,  0, 1,  1,  1,  0,   1, 4'd1});
        tbl.push_back('{"ld_x0",  7'h03, 3'd3, 7'h00, 5'd0, 0, 7,  0,  0, 1,  1,  1,  0,   1, 4'd1});
        tbl.push_back('{"sd",     7'h23, 3'd3, 7'h00, 5'd8, 0, 5,  0,  1, 0,  1,  0,  0,   1, 4'd1});
        tbl.push_back('{"beq_t",  7'h63, 3'd0, 7'h00, 5'd8, 1, 4,  0,  0, 0,  2,  0,  0,   2, 4'd1});
        tbl.push_back('{"beq_nt", 7'h63, 3'd0, 7'h00, 5'd8, 0, 4,  0,  0, 0,  1,  0,  0,   2, 4'd1});
        tbl.push_back('{"bne_nt", 7'h63, 3'd1, 7'h00, 5'd8, 1, 4,  0,  0, 0,  1,  0,  0,   2, 4'd1});
        tbl.push_back('{"bne_t",  7'h63, 3'd1, 7'h00, 5'd8, 0, 4,  0,  0, 0,  2,  0,  0,   2, 4'd1});
        tbl.push_back('{"ecall",  7'h73, 3'd0, 7'h00, 5'd0, 0, 25, 0,  0, 0,  1,  0,  22,  0, 4'd12});
        tbl.push_back('{"op7f",   7'h7f, 3'd0, 7'h00, 5'd0, 0, 25, 0,  0, 0,  1,  0,  22,  0, 4'd13});
        tbl.push_back('{"mul",    7'h33, 3'd0, 7'h01, 5'd3, 0, 25, 0,  0, 0,  1,  0,  22,  0, 4'd13});
        tbl.push_back('{"lw",     7'h03, 3'd2, 7'h00, 5'd5, 0, 25, 0,  0, 0,  1,  0,  22,  0, 4'd13});
        tbl.push_back('{"blt",    7'h63, 3'd4, 7'h00, 5'd8, 1, 25, 0,  0, 0,  1,  0,  22,  0, 4'd13});

        #2;
        do_reset("init");

        // Reset in the strobing FETCH cycle, then the post-release state sequence 0,1,1,2.
        @(negedge clock); #1;
        chk("midfetch.ir_load", 32'(ir_load), 32'd1);
        do_reset("midfetch");
        @(negedge clock); #1;
        chk("midfetch.fetch2", 32'(state), 32'd1);
        @(negedge clock); #1;
        chk("midfetch.decode", 32'(state), 32'd2);
        do_reset("after_decode");

        // Reset during the first MEM_RD cycle of a load.
        opcode = 7'h03; funct3 = 3'd3; funct7 = 7'h00; rd = 5'd5;
        repeat (4) @(negedge clock);
        #1;
        chk("midmemrd.state", 32'(state), 32'd7);
        do_reset("midmemrd");

        foreach (tbl[i]) measure(tbl[i]);

        run_random(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
